bus_timer: RTL

- Memory-mapped timer peripheral that acts as a responder on the CPU data bus, on the same bus as the RAM and UART.
- Provides a prescaled 32-bit up-counter, a compare register, a sticky match flag and an interrupt line.
- The top level decodes the peripheral's address window and feeds a qualified `mem_en` plus a word offset.
- Reads use the same one-cycle-later `ack` handshake the CPU already expects from RAM.

---
 rtl/bus_timer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/bus_timer.sv
// Memory-mapped timer: prescaled 32-bit counter, compare, sticky match, irq.
// Reads are acked one cycle after accept; writes are unacknowledged.
module bus_timer #(
    parameter int          PRESCALE_W  = 16,
    parameter logic [31:0] COMPARE_RST = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_en,
    input  logic        mem_write,
    input  logic [2:0]  addr,
    input  logic [3:0]  sel,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        ack,
    output logic        irq
);

    localparam logic [2:0] A_CTRL     = 3'd0;
    localparam logic [2:0] A_PRESCALE = 3'd1;
    localparam logic [2:0] A_COUNT    = 3'd2;
    localparam logic [2:0] A_COMPARE  = 3'd3;
    localparam logic [2:0] A_STATUS   = 3'd4;

    logic [2:0]            ctrl;
    logic [PRESCALE_W-1:0] prescale;
    logic [PRESCALE_W-1:0] pre_cnt;
    logic [31:0]           count;
    logic [31:0]           compare;
    logic                  match;

    logic                  wr;
    logic                  rd_acc;
    logic                  wr_ctrl;
    logic                  wr_pre;
    logic                  wr_count;
    logic                  wr_cmp;
    logic                  wr_stat;
    logic                  en;
    logic                  tick;
    logic                  match_hit;
    logic [31:0]           pre_wdata;
    logic [31:0]           rdata;

    function automatic logic [31:0] merge(
        input logic [31:0] old,
        input logic [31:0] wdata,
        input logic [3:0]  be
    );
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = wdata[8*i +: 8];
        end
        return r;
    endfunction

    assign wr       = mem_en & mem_write;
    assign rd_acc   = mem_en & ~mem_write & ~ack;
    assign wr_ctrl  = wr && (addr == A_CTRL);
    assign wr_pre   = wr && (addr == A_PRESCALE);
    assign wr_count = wr && (addr == A_COUNT);
    assign wr_cmp   = wr && (addr == A_COMPARE);
    assign wr_stat  = wr && (addr == A_STATUS);

    assign en        = ctrl[0];
    assign tick      = en && (pre_cnt == prescale);
    // compare always sees the pre-edge COMPARE, so a same-cycle write has no effect here
    assign match_hit = tick && (count == compare);
    assign pre_wdata = merge(32'(prescale), data_in, sel);
    assign irq       = match & ctrl[2];

    always_comb begin
        rdata = '0;
        case (addr)
            A_CTRL:     rdata = {29'd0, ctrl};
            A_PRESCALE: rdata = 32'(prescale);
            A_COUNT:    rdata = count;
            A_COMPARE:  rdata = compare;
            A_STATUS:   rdata = {31'd0, match};
            default:    rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl     <= '0;
            prescale <= '0;
            compare  <= COMPARE_RST;
        end else begin
            if (wr_ctrl && sel[0]) ctrl <= data_in[2:0];
            if (wr_pre) prescale <= pre_wdata[PRESCALE_W-1:0];
            if (wr_cmp) compare <= merge(compare, data_in, sel);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
        end else if (wr_pre || !en || tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PRESCALE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (wr_count) begin
            count <= merge(count, data_in, sel);
        end else if (tick) begin
            if (match_hit && ctrl[1]) count <= '0;
            else count <= count + 32'd1;
        end
    end

    // a set in the same cycle as a W1C clear wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match <= 1'b0;
        end else if (match_hit) begin
            match <= 1'b1;
        end else if (wr_stat && sel[0] && data_in[0]) begin
            match <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack      <= 1'b0;
            data_out <= '0;
        end else begin
            ack      <= rd_acc;
            data_out <= rd_acc ? rdata : '0;
        end
    end

endmodule
